// File: rtl/ex_div_pkg.sv
// Shared constants for the EX-stage divider: FSM encodings, handshake levels and default width.
package ex_div_pkg;

    localparam int DivWidth = 32;

    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/ex_div_neg.sv
// Conditional two's complement negate; shared by operand magnitude and result sign fix.
module ex_div_neg #(
    parameter int DATA_W = 32
) (
    input  logic              neg_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    assign data_o = neg_i ? (~data_i + DATA_W'(1)) : data_i;

endmodule

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one shift-subtract per cycle,
// result {remainder, quotient} held until EX drops start_i.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int DATA_W = DivWidth,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                sign1_q, sign1_d;
    logic                sign2_q, sign2_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic                op1_neg, op2_neg;
    logic [DATA_W-1:0]   op1_abs, op2_abs, quo_fix, rem_fix;
    logic [DATA_W:0]     trial;

    assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];

    ex_div_neg #(.DATA_W(DATA_W)) u_neg_op1 (.neg_i(op1_neg),           .data_i(opdata1_i), .data_o(op1_abs));
    ex_div_neg #(.DATA_W(DATA_W)) u_neg_op2 (.neg_i(op2_neg),           .data_i(opdata2_i), .data_o(op2_abs));
    ex_div_neg #(.DATA_W(DATA_W)) u_neg_quo (.neg_i(sign1_q ^ sign2_q), .data_i(quo_q),     .data_o(quo_fix));
    ex_div_neg #(.DATA_W(DATA_W)) u_neg_rem (.neg_i(sign1_q),           .data_i(rem_q),     .data_o(rem_fix));

    // Shifted partial remainder can reach DATA_W+1 bits, so the trial keeps the borrow.
    assign trial = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvs_q};

    always_comb begin
        // NOTE: every next-state signal defaults to its register so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        result_d = result_q;
        ready_d  = ready_q;

        case (state_q)
            DivFree: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    sign1_d = op1_neg;
                    sign2_d = op2_neg;
                    quo_d   = op1_abs;
                    dvs_d   = op2_abs;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                result_d = '0;
                ready_d  = DivResultReady;
                state_d  = DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                    state_d  = DivFree;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    if (!trial[DATA_W]) begin
                        rem_d = trial[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = DivResultReady;
                    state_d  = DivEnd;
                end
            end
            DivEnd: begin
                if (start_i == DivStop || annul_i) begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                    state_d  = DivFree;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all of it, datapath included, is reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: hand-computed quotients/remainders, latency, annul and reset behaviour.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_vec = 0;
    int n_bad = 0;

    ex_div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[10] = '{
        '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33},
        '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33},
        '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33},
        '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 33},
        '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33},
        '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33},
        '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33},
        '{1'b0, 32'd5,          32'd9,          64'h00000005_00000000, 33},
        '{1'b0, 32'h12345678,   32'd0,          64'h0,                 1},
        '{1'b1, 32'h80000000,   32'd0,          64'h0,                 1}
    };

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge is E0.
    task automatic launch(input logic sd, input logic [31:0] a, input logic [31:0] b);
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
    endtask

    // Counts edges from E0 until ready_o is seen (bounded), then checks latency and result.
    task automatic wait_ready(input string tag, input int exp_lat, input logic [63:0] exp_res,
                              input logic scramble);
        int lat;
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (scramble && k == 5) begin
                opdata1    = 32'hDEADBEEF;
                opdata2    = 32'd0;
                signed_div = ~signed_div;
            end
            if (ready) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, result, exp_res);
    endtask

    task automatic hold_and_drop(input string tag, input logic [63:0] exp_res);
        repeat (2) @(negedge clk);
        check({tag, "_hold_rdy"}, 64'(ready), 64'd1);
        check({tag, "_hold_res"}, result, exp_res);
        start = 1'b0;
        @(negedge clk);
        check({tag, "_drop_rdy"}, 64'(ready), 64'd0);
        check({tag, "_drop_res"}, result, 64'd0);
    endtask

    initial begin
        logic seen;
        rst        = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        start      = 1'b0;
        annul      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rdy", 64'(ready), 64'd0);
        check("reset_res", result, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].sd, vecs[i].a, vecs[i].b);
            wait_ready($sformatf("v%0d", i), vecs[i].lat, vecs[i].res, 1'b0);
            hold_and_drop($sformatf("v%0d", i), vecs[i].res);
        end

        // Annul mid-operation: return to IDLE, never signal ready, then a clean restart.
        launch(1'b0, 32'h1000, 32'd3);
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        launch(1'b0, 32'h10, 32'd4);
        wait_ready("after_annul", 33, 64'h00000000_00000004, 1'b0);
        hold_and_drop("after_annul", 64'h00000000_00000004);

        // Start and annul together in IDLE: annul wins, operation begins only once annul drops.
        launch(1'b0, 32'd100, 32'd7);
        annul = 1'b1;
        repeat (3) @(negedge clk);
        check("start_annul_idle", 64'(ready), 64'd0);
        annul = 1'b0;
        wait_ready("start_annul", 33, 64'h00000002_0000000E, 1'b0);
        hold_and_drop("start_annul", 64'h00000002_0000000E);

        // Operand inputs changing mid-operation must not disturb the result.
        launch(1'b0, 32'd100, 32'd7);
        wait_ready("scramble", 33, 64'h00000002_0000000E, 1'b1);
        hold_and_drop("scramble", 64'h00000002_0000000E);

        // Asynchronous reset mid-ON at step 20, then a full operation from scratch.
        launch(1'b0, 32'd100, 32'd7);
        repeat (21) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_on_rdy", 64'(ready), 64'd0);
        check("rst_on_res", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        launch(1'b0, 32'd100, 32'd7);
        wait_ready("after_rst", 33, 64'h00000002_0000000E, 1'b0);

        // Asynchronous reset while holding a result in END clears outputs without a clock.
        #2 rst = 1'b0;
        #1;
        check("rst_end_rdy", 64'(ready), 64'd0);
        check("rst_end_res", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 64'(ready), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative radix-2 restoring divider for the EX stage. Serves DIV and DIVU.
- Pairs with the combinational shift unit: that unit scales by 2^n, and this block performs the inverse scaling for arbitrary divisors, one shift-subtract per cycle.
- EX holds start_i and requests a pipeline stall until ready_o is seen.
- Result is {remainder, quotient}, written to HI/LO.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W bits.
- CNT_W, 6, step counter width; must hold the value DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  request. EX holds it high until ready_o is seen, then drops it.
- annul_i  in  1  cancel (branch delay flush or exception).
- result_o  out  2*DATA_W  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
- ready_o  out  1  result valid.

Behaviour:
- Reset: rst low asynchronously forces state IDLE, counter 0, result_o 0, ready_o 0. This applies at any point, including mid-operation.
- States: IDLE, BYZERO, ON, END. All outputs are registered.
- IDLE:
  - ready_o 0, result_o 0.
  - On an edge with start_i=1 and annul_i=0:
    - latch signed_div_i, opdata1_i, opdata2_i, and both operand signs;
    - if opdata2_i==0, go to BYZERO;
    - otherwise go to ON with counter 0 and remainder 0.
  - Operands are latched only at this edge; later input changes are ignored.
- Operand preparation (on entry to ON): if signed and an operand is negative, use its two's complement magnitude. The magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- ON, each edge:
  - If annul_i=1: go to IDLE; result_o and ready_o stay 0.
  - Else if counter < DATA_W:
    - shift {remainder, dividend} left by 1;
    - trial = remainder - divisor, computed DATA_W+1 bits wide;
    - if trial >= 0: remainder = trial, quotient LSB = 1; otherwise quotient LSB = 0;
    - counter += 1.
  - Else (counter == DATA_W):
    - sign fix: negate the quotient if signed and sign1^sign2; negate the remainder if signed and sign1;
    - register result_o = {rem, quo}, ready_o = 1, go to END.
- BYZERO: on the next edge, result_o = 0, ready_o = 1, go to END. There is no exception for divide by zero; the result is defined as zero.
- END:
  - Hold result_o and ready_o while start_i=1.
  - On an edge with start_i=0 or annul_i=1: go to IDLE, ready_o 0, result_o 0.
- Latency, with the start-sampling edge as E0:
  - normal: ready_o high after E33 (32 steps at E1..E32, fix at E33);
  - divide by zero: ready_o high after E1.
- Boundary results:
  - signed 0x80000000 / 0xFFFFFFFF gives quo 0x80000000, rem 0 (no trap).
  - Quotient truncates toward zero; remainder takes the dividend's sign.
- Simultaneous start_i and annul_i in IDLE: annul wins, stay IDLE.
- A new start requires passing through IDLE; there is no back-to-back start from END.

Decomposition:
- Add to defines.v:
  - state encodings DivFree / DivByZero / DivOn / DivEnd, 2 bits;
  - DivResultReady / DivResultNotReady;
  - DivStart / DivStop;
  - DivWidth.
- EXE_DIV_OP / EXE_DIVU_OP already belong there.
- Optional sub-module ex_div_neg: conditional two's complement negate, DATA_W wide. It is used for the operand magnitudes and for the sign fix.

Test Plan:
- Unsigned 100/7, start held → after exactly 33 edges ready_o=1, result_o={0x00000002, 0x0000000E}; drop start → ready_o 0 next edge.
- Signed -7/2 → {0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/-2 → {0x00000001, 0xFFFFFFFD}. Unsigned 0xFFFFFFF9/2 → {0x00000001, 0x7FFFFFFC}.
- Divisor 0, dividend 0x12345678 → ready_o=1 after E1, result_o=0; stays until start drops.
- Start 0x1000/3; pulse annul_i at step 10 → IDLE next edge, ready_o never asserts. Then start 0x10/4 → {0, 4} after 33 edges.
- Signed 0x80000000/0xFFFFFFFF → {0, 0x80000000}. Unsigned 0xFFFFFFFF/1 → {0, 0xFFFFFFFF}.
- Assert rst low asynchronously mid-ON at step 20 → ready_o, result_o 0 immediately with no clock. Also: change opdata1_i mid-ON → result unaffected.
